fft_cmult_stream: RTL and testbench

- Parametrised, streaming complex multiplier for the FFT butterfly and twiddle path; successor to the fixed-shift, fixed-latency multiplier.
- Adds the following:
  - Independent input and output widths.
  - Per-sample runtime shift.
  - Per-sample conjugate mode.
  - Round-half-up.
  - Saturation with a sticky overflow flag.
  - Sideband tag pass-through.
  - A valid/ready handshake with back-pressure.
- Sits between the twiddle ROM/data buffer and the butterfly adder stage.

---
 rtl/fft_cmult_stream.sv | 143 ++++++++++++++
 tb/tb_fft_cmult_stream.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_cmult_stream.sv
// Streaming complex multiplier for the FFT twiddle path: 4-stage valid/ready pipeline with
// per-sample conjugate, runtime round-half-up shift, saturation and tag pass-through.
module fft_cmult_stream #(
   parameter int unsigned IN_W  = 16,
   parameter int unsigned OUT_W = 16,
   parameter int unsigned TAG_W = 8,
   parameter int unsigned SH_W  = $clog2(2*IN_W+2)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [IN_W-1:0]  opa_r,
   input  logic signed [IN_W-1:0]  opa_i,
   input  logic signed [IN_W-1:0]  opb_r,
   input  logic signed [IN_W-1:0]  opb_i,
   input  logic                    conj,
   input  logic [SH_W-1:0]         shift,
   input  logic [TAG_W-1:0]        tag_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] out_r,
   output logic signed [OUT_W-1:0] out_i,
   output logic [TAG_W-1:0]        tag_out,
   output logic                    sat_now,
   output logic                    sat_sticky,
   input  logic                    sat_clr
);

   localparam int unsigned PW = 2*IN_W;
   localparam int unsigned SW = PW + 1;
   // Working width for round/shift: never narrower than the output plus a sign guard bit.
   localparam int unsigned CW = (PW + 2 > OUT_W) ? PW + 2 : OUT_W + 1;

   function automatic logic signed [PW-1:0] smul(input logic signed [IN_W-1:0] a,
                                                 input logic signed [IN_W-1:0] b);
      smul = $signed({{IN_W{a[IN_W-1]}}, a}) * $signed({{IN_W{b[IN_W-1]}}, b});
   endfunction

   function automatic logic signed [SW-1:0] sext(input logic signed [PW-1:0] p);
      sext = $signed({p[PW-1], p});
   endfunction

   // Returns {clipped, value}.
   function automatic logic [OUT_W:0] rnd_sat(input logic signed [SW-1:0] x,
                                              input logic [SH_W-1:0]      sh);
      logic [SH_W-1:0]         s;
      logic signed [CW-1:0]    ext;
      logic signed [CW-1:0]    rnd;
      logic signed [CW-1:0]    res;
      logic [CW-OUT_W:0]       hi;
      s   = (int'(sh) > int'(PW)) ? SH_W'(PW) : sh;
      ext = $signed({{(CW-SW){x[SW-1]}}, x});
      rnd = (s != '0) ? $signed(CW'(1) << (s - SH_W'(1))) : '0;
      res = (ext + rnd) >>> s;
      hi  = res[CW-1:OUT_W-1];
      if (&hi || !(|hi)) begin
         rnd_sat = {1'b0, res[OUT_W-1:0]};
      end else begin
         rnd_sat = {1'b1, res[CW-1], {(OUT_W-1){~res[CW-1]}}};
      end
   endfunction

   logic en;
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   logic                   v1, v2, v3;
   logic signed [IN_W-1:0] a_r1, a_i1, b_r1, b_i1;
   logic                   conj1, conj2;
   logic [SH_W-1:0]        sh1, sh2, sh3;
   logic [TAG_W-1:0]       tag1, tag2, tag3;
   logic signed [PW-1:0]   p_rr, p_ii, p_ir, p_ri;
   logic signed [SW-1:0]   sum_r3, sum_i3;
   logic [OUT_W:0]         res_r, res_i;

   always_comb begin
      res_r = rnd_sat(sum_r3, sh3);
      res_i = rnd_sat(sum_i3, sh3);
   end

   // Datapath registers need no reset: their contents are qualified by the valid bits.
   always_ff @(posedge clk) begin
      if (en) begin
         a_r1  <= opa_r;
         a_i1  <= opa_i;
         b_r1  <= opb_r;
         b_i1  <= opb_i;
         conj1 <= conj;
         sh1   <= shift;
         tag1  <= tag_in;

         p_rr  <= smul(a_r1, b_r1);
         p_ii  <= smul(a_i1, b_i1);
         p_ir  <= smul(a_i1, b_r1);
         p_ri  <= smul(a_r1, b_i1);
         conj2 <= conj1;
         sh2   <= sh1;
         tag2  <= tag1;

         sum_r3 <= conj2 ? sext(p_rr) + sext(p_ii) : sext(p_rr) - sext(p_ii);
         sum_i3 <= conj2 ? sext(p_ir) - sext(p_ri) : sext(p_ir) + sext(p_ri);
         sh3    <= sh2;
         tag3   <= tag2;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         v3        <= 1'b0;
         out_valid <= 1'b0;
         sat_now   <= 1'b0;
         out_r     <= '0;
         out_i     <= '0;
         tag_out   <= '0;
      end else if (en) begin
         v1        <= in_valid;
         v2        <= v1;
         v3        <= v2;
         out_valid <= v3;
         sat_now   <= v3 && (res_r[OUT_W] || res_i[OUT_W]);
         if (v3) begin
            out_r   <= res_r[OUT_W-1:0];
            out_i   <= res_i[OUT_W-1:0];
            tag_out <= tag3;
         end
      end
   end

   // A clipped sample leaving the block outranks a simultaneous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_sticky <= 1'b0;
      end else if (out_valid && out_ready && sat_now) begin
         sat_sticky <= 1'b1;
      end else if (sat_clr) begin
         sat_sticky <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fft_cmult_stream.sv
// Scoreboard bench for fft_cmult_stream: directed vectors push expectations, a negedge
// monitor pops and compares every output transfer.
module tb_fft_cmult_stream;

   localparam int IN_W  = 16;
   localparam int OUT_W = 16;
   localparam int TAG_W = 8;
   localparam int SH_W  = 6;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    in_valid;
   logic                    in_ready;
   logic signed [IN_W-1:0]  opa_r, opa_i, opb_r, opb_i;
   logic                    conj;
   logic [SH_W-1:0]         shift;
   logic [TAG_W-1:0]        tag_in;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [OUT_W-1:0] out_r, out_i;
   logic [TAG_W-1:0]        tag_out;
   logic                    sat_now;
   logic                    sat_sticky;
   logic                    sat_clr;

   fft_cmult_stream #(
      .IN_W (IN_W),
      .OUT_W(OUT_W),
      .TAG_W(TAG_W),
      .SH_W (SH_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opa_r     (opa_r),
      .opa_i     (opa_i),
      .opb_r     (opb_r),
      .opb_i     (opb_i),
      .conj      (conj),
      .shift     (shift),
      .tag_in    (tag_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_r     (out_r),
      .out_i     (out_i),
      .tag_out   (tag_out),
      .sat_now   (sat_now),
      .sat_sticky(sat_sticky),
      .sat_clr   (sat_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint r;
      longint i;
      int     tag;
      bit     sat;
      bit     chk_lat;
      int     exp_cyc;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: pops on every output transfer, checks stall stability and the ready relation.
   initial begin : monitor
      bit     prev_stall;
      longint h_r, h_i, h_t;
      exp_t   e;
      prev_stall = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            chk("in_ready_rel", in_ready, (!out_valid || out_ready));
            if (prev_stall) begin
               chk("stall_valid", out_valid, 1);
               chk("stall_r", out_r, h_r);
               chk("stall_i", out_i, h_i);
               chk("stall_tag", tag_out, h_t);
            end
            prev_stall = out_valid && !out_ready;
            h_r = out_r;
            h_i = out_i;
            h_t = tag_out;
            if (out_valid && out_ready) begin
               if (q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_out: got tag %0d r %0d, expected no output",
                           tag_out, out_r);
               end else begin
                  e = q.pop_front();
                  chk("out_r", out_r, e.r);
                  chk("out_i", out_i, e.i);
                  chk("tag", tag_out, e.tag);
                  chk("sat_now", sat_now, e.sat);
                  if (e.chk_lat) chk("latency", cyc, e.exp_cyc);
               end
            end
         end
      end
   end

   // Issue one sample; the accepting edge counts as the first of the four pipeline edges.
   task automatic send(input longint ar, input longint ai, input longint br, input longint bi,
                       input bit cj, input int sh, input int tg,
                       input longint er, input longint ei, input bit es, input bit lat);
      exp_t e;
      bit   acc;
      opa_r    = IN_W'(ar);
      opa_i    = IN_W'(ai);
      opb_r    = IN_W'(br);
      opb_i    = IN_W'(bi);
      conj     = cj;
      shift    = SH_W'(sh);
      tag_in   = TAG_W'(tg);
      in_valid = 1'b1;
      acc      = 1'b0;
      for (int k = 0; k < 200 && !acc; k++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!acc) begin
         chk("accept_timeout", 0, 1);
      end else begin
         e.r       = er;
         e.i       = ei;
         e.tag     = tg;
         e.sat     = es;
         e.chk_lat = lat;
         e.exp_cyc = cyc + 3;
         q.push_back(e);
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 100 && q.size() != 0; k++) @(negedge clk);
      if (q.size() != 0) chk("drain_timeout", q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_out();
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 50 && !seen; k++) begin
         @(negedge clk);
         seen = out_valid;
      end
      if (!seen) chk("out_timeout", 0, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      sat_clr   = 1'b0;
      opa_r = '0; opa_i = '0; opb_r = '0; opb_i = '0;
      conj = 1'b0; shift = '0; tag_in = '0;
      #22;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sat_now", sat_now, 0);
      chk("rst_sticky", sat_sticky, 0);
      chk("rst_out_r", out_r, 0);
      chk("rst_out_i", out_i, 0);
      chk("rst_tag", tag_out, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("post_rst_in_ready", in_ready, 1);
      out_ready = 1'b1;

      // Basic multiply and conjugate
      send(1000, 2000, 3, 4, 0, 0, 1, -5000, 10000, 0, 1);
      drain();
      send(1000, 2000, 3, 4, 1, 0, 2, 11000, 2000, 0, 1);
      drain();
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 0) send(1000, 2000, 3, 4, 0, 0, 10 + k, -5000, 10000, 0, 1);
         else            send(1000, 2000, 3, 4, 1, 0, 10 + k, 11000, 2000, 0, 1);
      end
      drain();

      // Rounding and shift clamp
      send(3, 0, 1, 0, 0, 1, 20, 2, 0, 0, 0);
      send(-3, 0, 1, 0, 0, 1, 21, -1, 0, 0, 0);
      send(5, 0, 1, 0, 0, 2, 22, 1, 0, 0, 0);
      send(-24, 0, 1, 0, 0, 4, 23, -1, 0, 0, 0);
      send(-32768, -32768, -32768, -32768, 1, 40, 24, 1, 0, 0, 0);
      send(-32768, -32768, -32768, -32768, 0, 40, 25, 0, 1, 0, 0);
      drain();
      chk("sticky_clean", sat_sticky, 0);

      // Saturation and sticky flag
      send(32767, 0, 32767, 0, 0, 0, 30, 32767, 0, 1, 0);
      wait_out();
      chk("sticky_before_xfer", sat_sticky, 0);
      @(posedge clk);
      #1;
      chk("sticky_after_xfer", sat_sticky, 1);
      sat_clr = 1'b1;
      @(posedge clk);
      #1;
      chk("sticky_cleared", sat_sticky, 0);
      send(32767, 0, 32767, 0, 0, 0, 31, 32767, 0, 1, 0);
      wait_out();
      @(posedge clk);
      #1;
      chk("sticky_set_wins", sat_sticky, 1);
      sat_clr = 1'b0;
      drain();
      send(32767, 0, -32768, 0, 0, 0, 32, -32768, 0, 1, 0);
      drain();

      // Back-pressure: A = 100t - j50t, B = 3 + j2 -> 400t + j50t
      fork
         begin
            for (int t = 0; t < 20; t++)
               send(100 * t, -50 * t, 3, 2, 0, 0, t, 400 * t, 50 * t, 0, 0);
         end
         begin
            for (int c = 0; c < 400 && !(c > 10 && q.size() == 0); c++) begin
               if (c >= 6 && c <= 9) out_ready = 1'b0;
               else if (c < 6)       out_ready = 1'b1;
               else                  out_ready = ($urandom_range(0, 3) != 0);
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      drain();

      // Reset with three samples in flight
      for (int k = 0; k < 3; k++) send(7, 0, 1, 0, 0, 0, 40 + k, 7, 0, 0, 0);
      @(posedge clk);
      #2;
      chk("pre_rst_valid", out_valid, 1);
      rst = 1'b1;
      #1;
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_tag", tag_out, 0);
      q.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rerelease_in_ready", in_ready, 1);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("no_stale", out_valid, 0);
      end
      @(posedge clk);
      #1;
      send(-7, 9, 2, -1, 0, 0, 50, -5, 25, 0, 1);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
